// File: rtl/usb_rx_nrzi_unstuff_pkg.sv
// Shared types and constants for the USB full-speed receive front end.
//   line_t   : decoded differential line state (J, K, SE0)
//   to_line  : maps a synchronized (D+, D-) pair onto line_t; (1,1) reads as J
package usb_rx_pkg;

  typedef enum logic [1:0] {LINE_J, LINE_K, LINE_SE0} line_t;

  localparam int USB_FS_CLKS_PER_BIT = 8;
  localparam int USB_STUFF_LEN       = 6;

  function automatic line_t to_line(input logic dp, input logic dm);
    line_t l;
    if (!dp && !dm) l = LINE_SE0;
    else if (!dp)   l = LINE_K;
    else            l = LINE_J;
    return l;
  endfunction

endpackage

// File: rtl/usb_rx_nrzi_unstuff_if.sv
// Line-side and decoded-bit-side signals of the receive front end.
//   d_plus, d_minus : synchronized USB line pair
//   clear           : synchronous abort back to idle
//   serial_out      : decoded data bit, valid with shift_en
//   shift_en        : one-cycle strobe for each unstuffed data bit
//   eop             : one-cycle strobe on end-of-packet
//   stuff_err       : one-cycle strobe on a bit-stuffing violation
// master drives the line and consumes the strobes; slave is the receiver.
interface usb_rx_nrzi_unstuff_if;
  logic d_plus;
  logic d_minus;
  logic clear;
  logic serial_out;
  logic shift_en;
  logic eop;
  logic stuff_err;

  modport master (output d_plus, d_minus, clear,
                  input  serial_out, shift_en, eop, stuff_err);
  modport slave  (input  d_plus, d_minus, clear,
                  output serial_out, shift_en, eop, stuff_err);
endinterface

// File: rtl/usb_rx_nrzi_unstuff_bit_timer.sv
// Bit-cell timer for the USB receiver. Restarts on every line transition and
// otherwise free-runs modulo CLKS_PER_BIT; sample pulses once per bit cell.
//   clk, rst : clock, asynchronous active-high reset
//   clear    : synchronous restart of the timer
//   resync   : a line transition was seen this cycle
//   sample   : take the bit this cycle
module usb_bit_timer #(
  parameter int CLKS_PER_BIT = 8,
  parameter int SAMPLE_POINT = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic resync,
  output logic sample
);

  localparam int TW = $clog2(CLKS_PER_BIT);
  localparam logic [TW-1:0] LAST = TW'(CLKS_PER_BIT - 1);
  localparam logic [TW-1:0] SPT  = TW'(SAMPLE_POINT);

  logic [TW-1:0] timer;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                  timer <= '0;
    else if (clear || resync) timer <= '0;
    else if (timer == LAST)   timer <= '0;
    else                      timer <= timer + TW'(1);
  end

  // A transition landing on the sample count moves the cell, so it wins.
  assign sample = (timer == SPT) && !resync;

endmodule

// File: rtl/usb_rx_nrzi_unstuff.sv
// USB full-speed receive bit recovery: bit timing, NRZI decode, unstuffing
// and end-of-packet detection.
//   clk, rst : clock, asynchronous active-high reset
//   bus      : slave side of usb_rx_nrzi_unstuff_if (line pair and clear in,
//              serial_out / shift_en / eop / stuff_err out, all registered)
module usb_rx_nrzi_unstuff
  import usb_rx_pkg::*;
#(
  parameter int CLKS_PER_BIT = USB_FS_CLKS_PER_BIT,
  parameter int SAMPLE_POINT = 3,
  parameter int STUFF_LEN    = USB_STUFF_LEN
) (
  input logic                  clk,
  input logic                  rst,
  usb_rx_nrzi_unstuff_if.slave bus
);

  localparam int OW = $clog2(STUFF_LEN + 1);
  localparam logic [OW-1:0] STUFF_AT = OW'(STUFF_LEN);

  line_t         line;
  logic          dp_hist;
  logic          resync;
  logic          sample;
  logic          dec_bit;
  logic          prev_line;
  logic [OW-1:0] ones_cnt;
  logic [1:0]    se0_cnt;
  logic          serial_q, shift_q, eop_q, err_q;

  always_comb begin
    line    = to_line(bus.d_plus, bus.d_minus);
    resync  = (bus.d_plus != dp_hist) && (line != LINE_SE0);
    dec_bit = (bus.d_plus == prev_line);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) dp_hist <= 1'b1;
    else     dp_hist <= bus.d_plus;
  end

  usb_bit_timer #(
    .CLKS_PER_BIT (CLKS_PER_BIT),
    .SAMPLE_POINT (SAMPLE_POINT)
  ) u_timer (
    .clk    (clk),
    .rst    (rst),
    .clear  (bus.clear),
    .resync (resync),
    .sample (sample)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      serial_q  <= 1'b1;
      shift_q   <= 1'b0;
      eop_q     <= 1'b0;
      err_q     <= 1'b0;
      ones_cnt  <= '0;
      prev_line <= 1'b1;
      se0_cnt   <= '0;
    end else begin
      shift_q <= 1'b0;
      eop_q   <= 1'b0;
      err_q   <= 1'b0;
      if (bus.clear) begin
        serial_q  <= 1'b1;
        ones_cnt  <= '0;
        prev_line <= 1'b1;
        se0_cnt   <= '0;
      end else if (sample) begin
        if (line == LINE_SE0) begin
          // Counter is cleared on EOP, so it never climbs past one.
          if (se0_cnt == 2'd1) begin
            eop_q     <= 1'b1;
            serial_q  <= 1'b1;
            ones_cnt  <= '0;
            prev_line <= 1'b1;
            se0_cnt   <= '0;
          end else begin
            se0_cnt <= se0_cnt + 2'd1;
          end
        end else begin
          prev_line <= bus.d_plus;
          se0_cnt   <= '0;
          if (ones_cnt < STUFF_AT) begin
            shift_q  <= 1'b1;
            serial_q <= dec_bit;
            ones_cnt <= dec_bit ? ones_cnt + OW'(1) : '0;
          end else begin
            // Stuffed position: a 0 is silently dropped, a 1 is a violation.
            err_q    <= dec_bit;
            ones_cnt <= '0;
          end
        end
      end
    end
  end

  assign bus.serial_out = serial_q;
  assign bus.shift_en   = shift_q;
  assign bus.eop        = eop_q;
  assign bus.stuff_err  = err_q;

endmodule
